// File: rtl/alineador_simbolos.sv
// Comma alignment for the serial 8b10b receive path: frames the bit stream into
// 10-bit symbols on K28.5 commas, keeps symbol lock and drops it after repeated
// off-phase commas.
module alineador_simbolos #(
    parameter int unsigned LOCK_COMMAS = 2,
    parameter int unsigned ERR_LIMIT   = 4
) (
    input  logic       clkRx,
    input  logic       rst,
    input  logic       enb,
    input  logic       serialIn,
    output logic [9:0] symbol,
    output logic       symValid,
    output logic       commaDet,
    output logic       locked,
    output logic       alignErr
);

    typedef enum logic [1:0] {StHunt, StCheck, StLocked} state_t;

    state_t     state_q, state_d;
    logic [9:0] w_q;
    logic [3:0] ph_q, ph_d;
    logic [3:0] c_cnt_q, c_cnt_d;
    logic [3:0] e_cnt_q, e_cnt_d;

    logic       hit, bnd;
    logic [3:0] ph_inc;
    logic [4:0] c_next, e_next;
    logic       emit, err;

    logic [9:0] symbol_q;
    logic       sym_valid_q, comma_det_q, locked_q, align_err_q;

    // Window holds the last ten bits, oldest in bit 0 so a framed symbol reads a..j.
    assign hit    = (w_q == 10'h17C) || (w_q == 10'h283);
    assign bnd    = (ph_q == 4'd0);
    assign ph_inc = (ph_q == 4'd9) ? 4'd0 : ph_q + 4'd1;
    assign c_next = {1'b0, c_cnt_q} + 5'd1;
    assign e_next = {1'b0, e_cnt_q} + 5'd1;

    // State, phase, window and counter registers.
    always_ff @(posedge clkRx) begin
        if (rst) begin
            state_q <= StHunt;
            w_q     <= '0;
            ph_q    <= '0;
            c_cnt_q <= '0;
            e_cnt_q <= '0;
        end else if (enb) begin
            state_q <= state_d;
            w_q     <= {serialIn, w_q[9:1]};
            ph_q    <= ph_d;
            c_cnt_q <= c_cnt_d;
            e_cnt_q <= e_cnt_d;
        end
    end

    // Next-state: lock acquisition, re-alignment and loss of lock.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_inc;
        c_cnt_d = c_cnt_q;
        e_cnt_d = e_cnt_q;
        unique case (state_q)
            StHunt: begin
                if (hit) begin
                    // A comma defines the boundary: this cycle acts as phase 0.
                    ph_d    = 4'd1;
                    c_cnt_d = 4'd1;
                    state_d = (LOCK_COMMAS <= 1) ? StLocked : StCheck;
                end
            end
            StCheck: begin
                if (bnd) begin
                    if (hit) begin
                        c_cnt_d = (c_cnt_q == 4'hF) ? c_cnt_q : c_next[3:0];
                        if (c_next >= 5'(LOCK_COMMAS)) begin
                            state_d = StLocked;
                        end
                    end
                end else if (hit) begin
                    ph_d    = 4'd1;
                    c_cnt_d = 4'd1;
                end
            end
            StLocked: begin
                if (bnd) begin
                    if (hit) begin
                        e_cnt_d = '0;
                    end
                end else if (hit) begin
                    e_cnt_d = (e_cnt_q == 4'hF) ? e_cnt_q : e_next[3:0];
                    if (e_next >= 5'(ERR_LIMIT)) begin
                        state_d = StHunt;
                        e_cnt_d = '0;
                        c_cnt_d = '0;
                    end
                end
            end
            default: state_d = StHunt;
        endcase
    end

    // Output decode: which cycles emit a symbol and which flag an alignment error.
    always_comb begin
        emit = 1'b0;
        err  = 1'b0;
        unique case (state_q)
            StHunt:   emit = hit;
            StCheck:  emit = bnd | hit;
            StLocked: begin
                emit = bnd;
                err  = hit & ~bnd;
            end
            default:  emit = 1'b0;
        endcase
    end

    // Registered outputs; strobes are cleared on disabled cycles.
    always_ff @(posedge clkRx) begin
        if (rst) begin
            symbol_q    <= '0;
            sym_valid_q <= 1'b0;
            comma_det_q <= 1'b0;
            locked_q    <= 1'b0;
            align_err_q <= 1'b0;
        end else if (enb) begin
            if (emit) begin
                symbol_q <= w_q;
            end
            sym_valid_q <= emit;
            comma_det_q <= emit & hit;
            locked_q    <= (state_q == StLocked);
            align_err_q <= err;
        end else begin
            sym_valid_q <= 1'b0;
            comma_det_q <= 1'b0;
            align_err_q <= 1'b0;
        end
    end

    assign symbol   = symbol_q;
    assign symValid = sym_valid_q;
    assign commaDet = comma_det_q;
    assign locked   = locked_q;
    assign alignErr = align_err_q;

endmodule

// File: tb/tb_alineador_simbolos.sv
// Bench for alineador_simbolos: directed scenarios plus randomized streams, checked
// by a scoreboard fed from a bit-level reference model of the alignment rules.
module tb_alineador_simbolos;

    localparam int LC = 2;
    localparam int EL = 4;

    logic       clk = 1'b0;
    logic       rst, enb, serialIn;
    logic [9:0] symbol;
    logic       symValid, commaDet, locked, alignErr;

    always #5 clk = ~clk;

    alineador_simbolos #(.LOCK_COMMAS(LC), .ERR_LIMIT(EL)) dut (
        .clkRx   (clk),
        .rst     (rst),
        .enb     (enb),
        .serialIn(serialIn),
        .symbol  (symbol),
        .symValid(symValid),
        .commaDet(commaDet),
        .locked  (locked),
        .alignErr(alignErr)
    );

    typedef struct {logic [9:0] sym; logic cd;} sym_t;
    typedef struct {logic lk; logic er; logic rs;} cyc_t;

    sym_t symq[$];
    cyc_t cycq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: mode 0 hunting, 1 confirming, 2 locked.
    int m_mode, m_pos, m_cc, m_ec;
    bit m_win[$];
    bit m_locked;

    function automatic void m_reset();
        m_mode = 0; m_pos = 0; m_cc = 0; m_ec = 0; m_locked = 0;
        m_win.delete();
        for (int i = 0; i < 10; i++) m_win.push_back(1'b0);
    endfunction

    function automatic void emit(input logic [9:0] s, input logic c);
        sym_t e;
        e.sym = s; e.cd = c;
        symq.push_back(e);
    endfunction

    function automatic void m_step(input bit b, output bit err);
        logic [9:0] wv;
        bit hit, bnd;
        for (int i = 0; i < 10; i++) wv[i] = m_win[i];
        hit = (wv == 10'h17C) || (wv == 10'h283);
        bnd = (m_pos % 10) == 0;
        err = 1'b0;
        m_locked = (m_mode == 2);
        case (m_mode)
            0: if (hit) begin
                emit(wv, 1'b1); m_pos = 0; m_cc = 1; m_mode = (LC <= 1) ? 2 : 1;
            end
            1: if (bnd) begin
                emit(wv, hit);
                if (hit) begin
                    m_cc++;
                    if (m_cc >= LC) m_mode = 2;
                end
            end else if (hit) begin
                emit(wv, 1'b1); m_pos = 0; m_cc = 1;
            end
            default: if (bnd) begin
                emit(wv, hit);
                if (hit) m_ec = 0;
            end else if (hit) begin
                err = 1'b1;
                m_ec++;
                if (m_ec >= EL) begin
                    m_mode = 0; m_ec = 0; m_cc = 0;
                end
            end
        endcase
        m_pos++;
        m_win.push_back(b);
        void'(m_win.pop_front());
    endfunction

    task automatic drive(input bit r, input bit e, input bit b);
        bit   err;
        cyc_t c;
        rst = r; enb = e; serialIn = b;
        err = 1'b0;
        if (r) m_reset();
        else if (e) m_step(b, err);
        c.lk = m_locked; c.er = err; c.rs = r;
        cycq.push_back(c);
        @(negedge clk);
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, s[i]);
    endtask

    task automatic send_rand_bits(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'($urandom));
    endtask

    task automatic send_sym_gappy(input logic [9:0] s);
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
            drive(1'b0, 1'b1, s[i]);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'($urandom), 1'($urandom));
    endtask

    // Monitor: per-cycle status checks, symbol checks on every strobe.
    always @(posedge clk) begin
        cyc_t c;
        sym_t e;
        #1;
        if (cycq.size() > 0) begin
            c = cycq.pop_front();
            total++;
            if (locked !== c.lk) begin
                bad++;
                $display("FAIL locked: got %b want %b at %0t", locked, c.lk, $time);
            end
            total++;
            if (alignErr !== c.er) begin
                bad++;
                $display("FAIL alignErr: got %b want %b at %0t", alignErr, c.er, $time);
            end
            if (c.rs) begin
                total++;
                if (symbol !== 10'h000 || symValid !== 1'b0 || commaDet !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_out: got sym=%h v=%b c=%b want 000/0/0 at %0t",
                             symbol, symValid, commaDet, $time);
                end
            end
            if (symValid === 1'b1) begin
                total++;
                if (symq.size() == 0) begin
                    bad++;
                    $display("FAIL extra_strobe: got sym=%h want no strobe at %0t",
                             symbol, $time);
                end else begin
                    e = symq.pop_front();
                    if (symbol !== e.sym || commaDet !== e.cd) begin
                        bad++;
                        $display("FAIL symbol: got %h/%b want %h/%b at %0t",
                                 symbol, commaDet, e.sym, e.cd, $time);
                    end
                end
            end else if (symq.size() > 0) begin
                total++;
                bad++;
                e = symq.pop_front();
                $display("FAIL missing_strobe: got v=%b want sym=%h at %0t",
                         symValid, e.sym, $time);
            end
        end
    end

    initial begin
        int r;
        m_reset();
        // Reset with random data on the line.
        do_reset(5);

        // Filler, two commas to lock, then data.
        drive(1'b0, 1'b1, 1'b1); drive(1'b0, 1'b1, 1'b0); drive(1'b0, 1'b1, 1'b1);
        send_sym(10'h17C); send_sym(10'h283);
        repeat (4) send_sym(10'h155);

        // One slipped bit, then six commas: four errors, loss of lock, relock.
        send_rand_bits(1);
        for (int i = 0; i < 6; i++) send_sym((i % 2) ? 10'h283 : 10'h17C);
        repeat (2) send_sym(10'h155);

        // Enable held low mid-symbol.
        send_sym(10'h0F3);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, r[0]);
        r = 32'h2D9;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, r[i]);
        idle(7);
        for (int i = 4; i < 10; i++) drive(1'b0, 1'b1, r[i]);
        send_sym(10'h155);

        // Reset mid-symbol, then relock.
        send_rand_bits(4);
        do_reset(1);
        send_rand_bits(3);
        send_sym(10'h17C); send_sym(10'h283);
        send_sym(10'h155);

        // Encoded bytes 00, CC, AB, 25 (running disparity starting negative).
        do_reset(1);
        send_rand_bits(7);
        send_sym(10'h17C); send_sym(10'h283);
        send_sym(10'h0B9); send_sym(10'h1AC); send_sym(10'h14B); send_sym(10'h265);
        send_sym(10'h155);

        // Randomized traffic: data, commas, slips, gaps, occasional reset.
        send_sym(10'h17C); send_sym(10'h283);
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 29);
            if (r < 3) send_sym(($urandom_range(0, 1) != 0) ? 10'h283 : 10'h17C);
            else if (r == 3) send_rand_bits($urandom_range(1, 9));
            else if (r == 4) idle($urandom_range(1, 6));
            else if (r == 5 && $urandom_range(0, 3) == 0) do_reset($urandom_range(1, 2));
            else send_sym_gappy(10'($urandom));
        end
        send_rand_bits(2);
        idle(2);

        @(posedge clk);
        #2;
        total++;
        if (symq.size() != 0) begin
            bad++;
            $display("FAIL leftover_symbols: got %0d pending want 0", symq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
